// File: rtl/vgatiming_gen.sv
// VGA raster timing generator with pixel-source handshake and a 2-clock output pipeline.
// Optional macro VGATIMING_SYNC_POS_EN selects active-high syncs (default: active-low).
module vgatiming_gen #(
    parameter int BITS_PER_COLOR = 4,
    parameter int HW             = 12,
    parameter int VW             = 12
) (
    input  logic                        i_pixclk,
    input  logic                        i_reset,
    input  logic [HW-1:0]               i_hm_width,
    input  logic [HW-1:0]               i_hm_porch,
    input  logic [HW-1:0]               i_hm_synch,
    input  logic [HW-1:0]               i_hm_raw,
    input  logic [VW-1:0]               i_vm_height,
    input  logic [VW-1:0]               i_vm_porch,
    input  logic [VW-1:0]               i_vm_synch,
    input  logic [VW-1:0]               i_vm_raw,
    output logic                        o_rd,
    output logic                        o_newline,
    output logic                        o_newframe,
    input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
    output logic                        o_vga_hsync,
    output logic                        o_vga_vsync,
    output logic [BITS_PER_COLOR-1:0]   o_vga_red,
    output logic [BITS_PER_COLOR-1:0]   o_vga_grn,
    output logic [BITS_PER_COLOR-1:0]   o_vga_blu
);

    localparam int BPC = BITS_PER_COLOR;
    localparam int BPP = 3 * BPC;

`ifdef VGATIMING_SYNC_POS_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif

    logic [HW-1:0]  sh_width, sh_porch, sh_synch, sh_raw;
    logic [VW-1:0]  sh_height, sh_vporch, sh_vsynch, sh_vraw;
    logic           reload;
    logic           mode_ok;
    logic [HW-1:0]  hpos, h_last;
    logic [VW-1:0]  vpos, v_last;
    logic           hs_raw, vs_raw;

    logic           rd_d, hs_d, vs_d;
    logic [BPP-1:0] colour_q;
    logic           hs_q, vs_q;

    assign mode_ok = (sh_width  != '0) && (sh_width  < sh_porch)  &&
                     (sh_porch  < sh_synch)  && (sh_synch  < sh_raw) &&
                     (sh_height != '0) && (sh_height < sh_vporch) &&
                     (sh_vporch < sh_vsynch) && (sh_vsynch < sh_vraw);

    assign h_last = sh_raw  - HW'(1);
    assign v_last = sh_vraw - VW'(1);

    // Shadow mode: reloads after reset, at frame end, and every clock while invalid
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            reload    <= 1'b1;
            sh_width  <= '0;
            sh_porch  <= '0;
            sh_synch  <= '0;
            sh_raw    <= '0;
            sh_height <= '0;
            sh_vporch <= '0;
            sh_vsynch <= '0;
            sh_vraw   <= '0;
        end else begin
            reload <= 1'b0;
            if (reload || o_newframe || !mode_ok) begin
                sh_width  <= i_hm_width;
                sh_porch  <= i_hm_porch;
                sh_synch  <= i_hm_synch;
                sh_raw    <= i_hm_raw;
                sh_height <= i_vm_height;
                sh_vporch <= i_vm_porch;
                sh_vsynch <= i_vm_synch;
                sh_vraw   <= i_vm_raw;
            end
        end
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (!mode_ok) begin
            hpos <= '0;
            vpos <= '0;
        end else if (hpos == h_last) begin
            hpos <= '0;
            vpos <= (vpos == v_last) ? '0 : vpos + VW'(1);
        end else begin
            hpos <= hpos + HW'(1);
        end
    end

    always_comb begin
        o_rd       = 1'b0;
        o_newline  = 1'b0;
        o_newframe = 1'b0;
        hs_raw     = 1'b0;
        vs_raw     = 1'b0;
        if (mode_ok) begin
            o_rd       = (hpos < sh_width) && (vpos < sh_height);
            o_newline  = (hpos == h_last);
            o_newframe = (hpos == h_last) && (vpos == v_last);
            hs_raw     = (hpos >= sh_porch)  && (hpos < sh_synch);
            vs_raw     = (vpos >= sh_vporch) && (vpos < sh_vsynch);
        end
    end

    // Syncs travel the pipeline as active-high flags; polarity is applied at the pins
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            rd_d     <= 1'b0;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            colour_q <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            rd_d     <= o_rd;
            hs_d     <= hs_raw;
            vs_d     <= vs_raw;
            colour_q <= rd_d ? i_pixel : '0;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign o_vga_hsync = hs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vga_vsync = vs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vga_red   = colour_q[BPP-1   -: BPC];
    assign o_vga_grn   = colour_q[2*BPC-1 -: BPC];
    assign o_vga_blu   = colour_q[BPC-1:0];

endmodule

// File: doc/vgatiming_gen.md
Name: vgatiming_gen

Overview:
- Generates VGA raster timing and drives the pixel-source handshake (o_rd, o_newline, o_newframe) for pattern sources such as the colour-bar/test-image generator.
- Accepts the source's registered pixel one clock after o_rd, gates it with blanking, and drives the VGA pins with aligned syncs.
- Sits between the pixel source and the board VGA/DVI encoder.

Parameters:
- BITS_PER_COLOR, 4, bits per colour channel (BPC); pixel width BPP = 3*BPC.
- HW, 12, width of horizontal counter and horizontal mode inputs.
- VW, 12, width of vertical counter and vertical mode inputs.

Ports:
- i_pixclk  input  1  pixel clock; all logic on posedge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_hm_width  input  HW  active pixels per line.
- i_hm_porch  input  HW  hpos at which hsync asserts.
- i_hm_synch  input  HW  hpos at which hsync deasserts.
- i_hm_raw  input  HW  total clocks per line.
- i_vm_height  input  VW  active lines per frame.
- i_vm_porch  input  VW  line at which vsync asserts.
- i_vm_synch  input  VW  line at which vsync deasserts.
- i_vm_raw  input  VW  total lines per frame.
- o_rd  output  1  request one pixel from the source this cycle.
- o_newline  output  1  one-cycle pulse on the last clock of each line.
- o_newframe  output  1  one-cycle pulse on the last clock of each frame.
- i_pixel  input  BPP  source pixel {R,G,B}, valid one clock after o_rd.
- o_vga_hsync  output  1  horizontal sync.
- o_vga_vsync  output  1  vertical sync.
- o_vga_red  output  BPC  red channel.
- o_vga_grn  output  BPC  green channel.
- o_vga_blu  output  BPC  blue channel.

Behaviour:
- Mode shadow: all eight mode inputs are captured into shadow registers on the first clock after reset deasserts, and again on every clock where o_newframe=1. Mid-frame input changes have no effect.
- Mode valid: 0 < width < porch < synch < raw, and 0 < height < vporch < vsynch < vraw.
  - If the shadow mode is invalid: counters are held at 0, o_rd/o_newline/o_newframe=0, syncs inactive, colour=0.
  - An invalid mode is re-captured every clock until it becomes valid; counting then starts at (0,0).
- Counters: hpos runs 0..raw-1.
  - At hpos=raw-1, hpos wraps to 0 and vpos increments.
  - vpos runs 0..vraw-1 and wraps to 0 at hpos=raw-1, vpos=vraw-1.
- Handshake, combinational from registered counter state (h,v) in the same cycle:
  - o_rd = (h<width) && (v<height).
  - o_newline = (h==raw-1).
  - o_newframe = o_newline && (v==vraw-1).
  - o_rd is never high on the same cycle as o_newline.
- Raw syncs: hs_raw = (h>=porch && h<synch); vs_raw = (v>=vporch && v<vsynch).
- Output pipeline, fixed 2-clock latency from counter state to pins:
  - Stage 1 registers rd_d=o_rd, hs_d, vs_d.
  - Stage 2 registers colour = rd_d ? i_pixel : 0, split MSB-first into red/grn/blu, and the syncs from hs_d/vs_d.
- Reset (asynchronous, any time including mid-line):
  - hpos=vpos=0, all handshake outputs 0, pipeline cleared, colour=0, syncs inactive.
  - Shadow marked for reload.
- Arithmetic: comparisons are unsigned at HW/VW width; counter overflow is impossible because raw is bounded by HW.

Optional Feature:
- Macro: VGATIMING_SYNC_POS_EN.
- Defined: syncs are active-high (inactive=0, including during reset).
- Undefined: syncs are active-low, per standard 640x480 (inactive=1, including during reset).

Test Plan:
- Tiny mode 4/5/6/8, 2/3/4/5, i_pixel held 12'hABC -> o_rd high at h=0..3 for v=0,1; o_newline at h=7 of every line; o_newframe once per 40 clocks; o_vga_red/grn/blu = A/B/C exactly 2 clocks after each o_rd, 0 otherwise.
- Same tiny mode, sync timing -> hsync active at h=5 only, appearing at the pins 2 clocks later; vsync active for all of line 3 only.
- 640x480 (640,656,752,800 / 480,490,492,525) -> 640 o_rd per line, 307200 o_rd per frame, frame period 420000 clocks.
- Change i_hm_width from 640 to 320 mid-frame -> current frame keeps 640; the next frame, after o_newframe, has 320 o_rd per line.
- Invalid mode (porch=width) after reset -> all outputs idle/inactive; switch to a valid mode -> first o_rd on the next clock at (0,0).
- Assert i_reset at h=100, v=50 -> outputs clear immediately without a clock edge; after release, the shadow is reloaded and counting restarts at (0,0).
